tdm_wavetable_reader: RTL and testbench



---
 rtl/tdm_wavetable_reader_pkg.sv | 35 +++
 rtl/wt_rom.sv | 34 +++
 rtl/tdm_wavetable_reader.sv | 203 ++++++++++++++++++++
 tb/tb_tdm_wavetable_reader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_wavetable_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_wavetable_reader_pkg
// Description : Shared definitions for the TDM wavetable reader: wave index
//               constants, FSM state encoding and the table-entry helper.
// Revision    : 1.0  initial release
// ============================================================================
package tdm_wavetable_reader_pkg;

    // Wave index constants
    localparam int WAVE_SIN = 0;
    localparam int WAVE_TRI = 1;
    localparam int WAVE_SQR = 2;
    localparam int WAVE_SAW = 3;

    // Width of the table tag held in the top bits of every table entry
    localparam int TAG_BITS = 4;

    // FSM state encoding (ISSUE2/INTERP are only visited in the interpolating build)
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_ISSUE2  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_INTERP  = 3'd4,
        ST_PRESENT = 3'd5
    } state_t;

    // Table entry: table index in the top TAG_BITS, address in the low bits
    function automatic logic [31:0] wt_entry(input int wave_id, input int addr, input int d_w);
        return 32'((wave_id << (d_w - TAG_BITS)) | addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wt_rom.sv
`default_nettype none
// ============================================================================
// Module      : wt_rom
// Description : Synchronous-read, clock-enabled wavetable ROM. Each entry
//               carries its table index in the top nibble and its address
//               in the low bits, so every read is self-identifying.
// Revision    : 1.0  initial release
// ============================================================================
module wt_rom
    import tdm_wavetable_reader_pkg::*;
#(
    parameter int D_W       = 16,
    parameter int ADDR_BITS = 8,
    parameter int WAVE_ID   = 0
) (
    input  logic                 sys_clk,
    input  logic                 en,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [D_W-1:0]       q
);

    logic [D_W-1:0] r_q;

    // One-cycle registered read; output holds when not enabled
    always_ff @(posedge sys_clk) begin
        if (en) begin
            r_q <= D_W'(wt_entry(WAVE_ID, int'(addr), D_W));
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/tdm_wavetable_reader.sv
`default_nettype none
// ============================================================================
// Module      : tdm_wavetable_reader
// Description : Time-division-multiplexed wavetable reader. Snapshots every
//               voice's phase and wave select on frame_start, then visits the
//               voices in order and streams one sample per voice out on a
//               valid/ready interface.
//               Build option TDM_WT_INTERP_EN: linear interpolation between
//               adjacent table entries (5 cycles per voice instead of 3).
// Revision    : 1.0  initial release
// ============================================================================
module tdm_wavetable_reader
    import tdm_wavetable_reader_pkg::*;
#(
    parameter int D_W        = 16,
    parameter int VOICES     = 8,
    parameter int VOICE_BITS = 3,
    parameter int WAVES      = 4,
    parameter int WAVE_BITS  = 2,
    parameter int ADDR_BITS  = 8,
    parameter int PHASE_W    = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          frame_start,
    input  logic [VOICES*PHASE_W-1:0]     voice_phase,
    input  logic [VOICES*WAVE_BITS-1:0]   voice_wave,
    output logic [D_W-1:0]                sample_out,
    output logic [VOICE_BITS-1:0]         sample_voice,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          frame_done,
    output logic                          busy
);

    localparam int                    FRAC_W     = PHASE_W - ADDR_BITS;
    localparam logic [VOICE_BITS-1:0] LAST_VOICE = VOICE_BITS'(VOICES - 1);

    state_t                        r_state;
    logic [VOICES*PHASE_W-1:0]     r_phase;
    logic [VOICES*WAVE_BITS-1:0]   r_wave;
    logic [VOICE_BITS-1:0]         r_voice;
    logic [D_W-1:0]                r_sample_out;
    logic [VOICE_BITS-1:0]         r_sample_voice;
    logic                          r_sample_valid;
    logic                          r_frame_done;
    logic                          r_busy;

    logic [PHASE_W-1:0]            w_phase_v;
    logic [WAVE_BITS-1:0]          w_wave_v;
    logic [ADDR_BITS-1:0]          w_addr;
    logic [ADDR_BITS-1:0]          w_rom_addr;
    logic                          w_rom_en;
    logic [D_W-1:0]                w_rom_q [WAVES];
    logic [D_W-1:0]                w_sel;

    // Current voice's snapshot fields
    assign w_phase_v = r_phase[r_voice*PHASE_W +: PHASE_W];
    assign w_wave_v  = r_wave[r_voice*WAVE_BITS +: WAVE_BITS];
    assign w_addr    = w_phase_v[PHASE_W-1 -: ADDR_BITS];

`ifdef TDM_WT_INTERP_EN
    localparam int PW = D_W + FRAC_W + 2;

    logic [D_W-1:0]         r_s0;
    logic [D_W-1:0]         r_s1;
    logic [FRAC_W-1:0]      w_frac;
    logic signed [D_W:0]    w_diff;
    logic signed [PW-1:0]   w_prod;
    logic signed [PW-1:0]   w_sum;
    logic [D_W-1:0]         w_interp;
    logic                   w_unused_interp;

    // Two reads per voice: entry a, then entry a+1 (wrapping at the table end)
    assign w_rom_en   = (r_state == ST_ISSUE) || (r_state == ST_ISSUE2);
    assign w_rom_addr = (r_state == ST_ISSUE2) ? (w_addr + ADDR_BITS'(1)) : w_addr;

    // s0 + ((s1 - s0) * frac) >>> FRAC_W, keeping the low D_W bits
    assign w_frac          = w_phase_v[FRAC_W-1:0];
    assign w_diff          = $signed({r_s1[D_W-1], r_s1}) - $signed({r_s0[D_W-1], r_s0});
    assign w_prod          = PW'(w_diff) * $signed(PW'({1'b0, w_frac}));
    assign w_sum           = PW'($signed(r_s0)) + (w_prod >>> FRAC_W);
    assign w_interp        = w_sum[D_W-1:0];
    assign w_unused_interp = ^w_sum[PW-1:D_W];
`else
    logic w_unused_frac;

    // Nearest-sample: a single read per voice; the fraction is discarded
    assign w_rom_en      = (r_state == ST_ISSUE);
    assign w_rom_addr    = w_addr;
    assign w_unused_frac = ^w_phase_v[FRAC_W-1:0];
`endif

    // One ROM per wave; all share the address and read enable
    for (genvar g = 0; g < WAVES; g++) begin : g_rom
        wt_rom #(
            .D_W       (D_W),
            .ADDR_BITS (ADDR_BITS),
            .WAVE_ID   (g)
        ) u_rom (
            .sys_clk (sys_clk),
            .en      (w_rom_en),
            .addr    (w_rom_addr),
            .q       (w_rom_q[g])
        );
    end

    // Select the voice's table; an out-of-range wave select yields zero
    always_comb begin
        w_sel = '0;
        for (int w = 0; w < WAVES; w++) begin
            if (w_wave_v == WAVE_BITS'(w)) begin
                w_sel = w_rom_q[w];
            end
        end
    end

    // Frame sequencer with registered stream outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state        <= ST_IDLE;
            r_phase        <= '0;
            r_wave         <= '0;
            r_voice        <= '0;
            r_sample_out   <= '0;
            r_sample_voice <= '0;
            r_sample_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_busy         <= 1'b0;
`ifdef TDM_WT_INTERP_EN
            r_s0           <= '0;
            r_s1           <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_phase <= voice_phase;
                        r_wave  <= voice_wave;
                        r_voice <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef TDM_WT_INTERP_EN
                    r_state <= ST_ISSUE2;
`else
                    r_state <= ST_CAPTURE;
`endif
                end
`ifdef TDM_WT_INTERP_EN
                ST_ISSUE2: begin
                    r_s0    <= w_sel;
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_s1    <= w_sel;
                    r_state <= ST_INTERP;
                end
                ST_INTERP: begin
                    r_sample_out   <= w_interp;
                    r_sample_voice <= r_voice;
                    r_sample_valid <= 1'b1;
                    r_state        <= ST_PRESENT;
                end
`else
                ST_CAPTURE: begin
                    r_sample_out   <= w_sel;
                    r_sample_voice <= r_voice;
                    r_sample_valid <= 1'b1;
                    r_state        <= ST_PRESENT;
                end
`endif
                ST_PRESENT: begin
                    if (sample_ready) begin
                        r_sample_valid <= 1'b0;
                        if (r_voice == LAST_VOICE) begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_voice <= r_voice + VOICE_BITS'(1);
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample_out   = r_sample_out;
    assign sample_voice = r_sample_voice;
    assign sample_valid = r_sample_valid;
    assign frame_done   = r_frame_done;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tdm_wavetable_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_wavetable_reader
// Description : Scoreboard bench for tdm_wavetable_reader. Two instances (4
//               tables and 3 tables) share stimulus; expected samples are
//               queued per frame from a reference model and popped by a
//               monitor on every accepted sample.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tdm_wavetable_reader;

    localparam int D_W        = 16;
    localparam int VOICES     = 8;
    localparam int VOICE_BITS = 3;
    localparam int WAVE_BITS  = 2;
    localparam int ADDR_BITS  = 8;
    localparam int PHASE_W    = 16;
    localparam int FRAC_W     = PHASE_W - ADDR_BITS;
`ifdef TDM_WT_INTERP_EN
    localparam int CPV = 5;
`else
    localparam int CPV = 3;
`endif

    logic                        sys_clk      = 1'b0;
    logic                        sys_rst_n    = 1'b0;
    logic                        frame_start  = 1'b0;
    logic                        sample_ready = 1'b1;
    logic [VOICES*PHASE_W-1:0]   voice_phase  = '0;
    logic [VOICES*WAVE_BITS-1:0] voice_wave   = '0;

    logic [D_W-1:0]        sample_out,   s3_out;
    logic [VOICE_BITS-1:0] sample_voice, s3_voice;
    logic                  sample_valid, s3_valid;
    logic                  frame_done,   s3_done;
    logic                  busy,         s3_busy;

    tdm_wavetable_reader #(
        .D_W(D_W), .VOICES(VOICES), .VOICE_BITS(VOICE_BITS), .WAVES(4),
        .WAVE_BITS(WAVE_BITS), .ADDR_BITS(ADDR_BITS), .PHASE_W(PHASE_W)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start),
        .voice_phase(voice_phase), .voice_wave(voice_wave),
        .sample_out(sample_out), .sample_voice(sample_voice),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .frame_done(frame_done), .busy(busy)
    );

    tdm_wavetable_reader #(
        .D_W(D_W), .VOICES(VOICES), .VOICE_BITS(VOICE_BITS), .WAVES(3),
        .WAVE_BITS(WAVE_BITS), .ADDR_BITS(ADDR_BITS), .PHASE_W(PHASE_W)
    ) dut3 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start),
        .voice_phase(voice_phase), .voice_wave(voice_wave),
        .sample_out(s3_out), .sample_voice(s3_voice),
        .sample_valid(s3_valid), .sample_ready(sample_ready),
        .frame_done(s3_done), .busy(s3_busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [VOICE_BITS-1:0] voice;
        logic [D_W-1:0]        data;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];

    int errors      = 0;
    int checks      = 0;
    int ready_mode  = 0;
    int stall_left  = 0;
    bit stall_armed = 1'b0;
    int stall_count = 0;

    logic                  p_valid = 1'b0;
    logic                  p_ready = 1'b0;
    logic [D_W-1:0]        p_data  = '0;
    logic [VOICE_BITS-1:0] p_voice = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference table: table index in the top nibble, address in the low byte
    function automatic logic [D_W-1:0] tbl(input int nwaves, input int w, input int a);
        if (w >= nwaves) return '0;
        return D_W'((w << (D_W - 4)) | a);
    endfunction

    function automatic logic [D_W-1:0] model(input int nwaves, input int w, input logic [PHASE_W-1:0] ph);
        int a;
`ifdef TDM_WT_INTERP_EN
        int s0, s1, f, r;
`endif
        a = int'(ph[PHASE_W-1 -: ADDR_BITS]);
`ifdef TDM_WT_INTERP_EN
        s0 = int'($signed(tbl(nwaves, w, a)));
        s1 = int'($signed(tbl(nwaves, w, (a + 1) % (1 << ADDR_BITS))));
        f  = int'(ph[FRAC_W-1:0]);
        r  = s0 + (((s1 - s0) * f) >>> FRAC_W);
        return D_W'(r);
`else
        return tbl(nwaves, w, a);
`endif
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int v = 0; v < VOICES; v++) begin
            e.voice = VOICE_BITS'(v);
            e.data  = model(4, int'(voice_wave[v*WAVE_BITS +: WAVE_BITS]), voice_phase[v*PHASE_W +: PHASE_W]);
            q4.push_back(e);
            e.data  = model(3, int'(voice_wave[v*WAVE_BITS +: WAVE_BITS]), voice_phase[v*PHASE_W +: PHASE_W]);
            q3.push_back(e);
        end
    endtask

    // Monitor: pop and compare on every handshake, check hold under stall
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n) begin
                if (p_valid && !p_ready) begin
                    chk("hold_valid", 32'(sample_valid), 32'(1));
                    chk("hold_data",  32'(sample_out),   32'(p_data));
                    chk("hold_voice", 32'(sample_voice), 32'(p_voice));
                end
                if (sample_valid && sample_ready) begin
                    if (q4.size() == 0) chk("unexpected_sample", 32'(1), 32'(0));
                    else begin
                        e = q4.pop_front();
                        chk("sample_voice", 32'(sample_voice), 32'(e.voice));
                        chk("sample_data",  32'(sample_out),   32'(e.data));
                    end
                end
                if (s3_valid && sample_ready) begin
                    if (q3.size() == 0) chk("unexpected_sample_w3", 32'(1), 32'(0));
                    else begin
                        e = q3.pop_front();
                        chk("sample_voice_w3", 32'(s3_voice), 32'(e.voice));
                        chk("sample_data_w3",  32'(s3_out),   32'(e.data));
                    end
                end
                if (sample_valid && !sample_ready) stall_count++;
                p_valid = sample_valid;
                p_ready = sample_ready;
                p_data  = sample_out;
                p_voice = sample_voice;
            end else begin
                p_valid = 1'b0;
            end
        end
    end

    // Ready driver: 0 always ready, 1 random, 2 four-cycle stall on voice 2
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            case (ready_mode)
                0: sample_ready = 1'b1;
                1: sample_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (stall_armed && sample_valid && sample_voice == VOICE_BITS'(2)) begin
                        stall_armed = 1'b0;
                        stall_left  = 4;
                    end
                    if (stall_left > 0) begin
                        sample_ready = 1'b0;
                        stall_left--;
                    end else begin
                        sample_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic randomize_inputs();
        for (int v = 0; v < VOICES; v++) begin
            voice_phase[v*PHASE_W +: PHASE_W]   = PHASE_W'($urandom);
            voice_wave[v*WAVE_BITS +: WAVE_BITS] = WAVE_BITS'($urandom);
        end
    endtask

    task automatic run_frame(input int mode, input bit directed, input bit reissue,
                             input bit restart_on_done, input bit mid_reset);
        int n;
        int first;
        bit seen_done;
        @(posedge sys_clk);
        #1;
        if (directed) begin
            for (int v = 0; v < VOICES; v++) begin
                voice_phase[v*PHASE_W +: PHASE_W]   = PHASE_W'(v * 32'h1000);
                voice_wave[v*WAVE_BITS +: WAVE_BITS] = WAVE_BITS'(v % 4);
            end
        end else begin
            randomize_inputs();
        end
        ready_mode  = mode;
        stall_armed = (mode == 2);
        stall_count = 0;
        push_frame();
        frame_start = 1'b1;
        n = 0;
        first = -1;
        seen_done = 1'b0;
        while (n < 400 && !seen_done) begin
            @(posedge sys_clk);
            n++;
            @(negedge sys_clk);
            if (n == 1) begin
                frame_start = 1'b0;
                chk("busy_set", 32'(busy), 32'(1));
            end
            if (reissue && n == 4) begin
                randomize_inputs();
                frame_start = 1'b1;
            end
            if (reissue && n == 5) frame_start = 1'b0;
            if (restart_on_done && n == CPV*VOICES)     frame_start = 1'b1;
            if (restart_on_done && n == CPV*VOICES + 1) frame_start = 1'b0;
            if (mid_reset && n == 10) begin
                sys_rst_n = 1'b0;
                #1;
                chk("rst_sample_out",   32'(sample_out),   32'(0));
                chk("rst_sample_voice", 32'(sample_voice), 32'(0));
                chk("rst_sample_valid", 32'(sample_valid), 32'(0));
                chk("rst_frame_done",   32'(frame_done),   32'(0));
                chk("rst_busy",         32'(busy),         32'(0));
                chk("rst_busy_w3",      32'(s3_busy),      32'(0));
                q4.delete();
                q3.delete();
                p_valid = 1'b0;
                #3;
                sys_rst_n = 1'b1;
                return;
            end
            if (first < 0 && sample_valid) first = n;
            if (frame_done) seen_done = 1'b1;
        end
        chk("frame_done_seen", 32'(seen_done), 32'(1));
        chk("first_valid_latency", 32'(first), 32'(CPV));
        if (mode == 2) chk("frame_len_stall", 32'(n), 32'(CPV*VOICES + 1 + 4));
        else           chk("frame_len", 32'(n), 32'(CPV*VOICES + 1 + stall_count));
        chk("frame_done_w3", 32'(s3_done), 32'(1));
        @(negedge sys_clk);
        chk("busy_clear", 32'(busy), 32'(0));
        chk("scoreboard_drained", 32'(q4.size() + q3.size()), 32'(0));
        if (restart_on_done) begin
            repeat (3) @(negedge sys_clk);
            chk("restart_ignored_busy",  32'(busy),         32'(0));
            chk("restart_ignored_valid", 32'(sample_valid), 32'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_sample_out",   32'(sample_out),   32'(0));
        chk("reset_sample_voice", 32'(sample_voice), 32'(0));
        chk("reset_sample_valid", 32'(sample_valid), 32'(0));
        chk("reset_frame_done",   32'(frame_done),   32'(0));
        chk("reset_busy",         32'(busy),         32'(0));
        sys_rst_n = 1'b1;

        run_frame(0, 1'b1, 1'b0, 1'b0, 1'b0);   // directed table sweep
        run_frame(2, 1'b1, 1'b0, 1'b0, 1'b0);   // backpressure on voice 2
        run_frame(0, 1'b0, 1'b1, 1'b0, 1'b0);   // frame_start while busy
        run_frame(0, 1'b0, 1'b0, 1'b1, 1'b0);   // frame_start with frame_done
        run_frame(0, 1'b0, 1'b0, 1'b0, 1'b1);   // reset mid-frame
        run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0);   // clean restart after reset
        for (int i = 0; i < 6; i++) begin
            run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0); // random ready
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
